serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor, the inverse-direction companion to the team's 4-bit ripple-carry adder. It computes `a - b - bin` one bit per clock, LSB first, through a single registered borrow flip-flop, and returns a full-width difference plus borrow-out under a start/done handshake. It serves area-constrained datapaths and provides a cycle-accurate subtraction reference that runs alongside the combinational adder.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and a counter-width helper.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = x - y - bi, with borrow-out bo.
// Combinational mirror of the adder's full-adder cell.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one bit per clock,
// with a start/done handshake and registered full-width difference and borrow-out.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_part_next;

  full_subtractor u_cell (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last      = (r_cnt == LAST_BIT);
  // New difference bit enters at the MSB; after WIDTH shifts bit 0 holds d0.
  assign w_part_next = WIDTH'({w_d, r_part} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_part   <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          r_part   <= w_part_next;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Result registers move only on the last bit so diff/bout hold between ops.
          if (w_last) begin
            r_diff  <= w_part_next;
            r_bout  <= w_bo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 4.
// Expected results are queued at launch and compared whenever done pulses.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_exp   = 0;

  logic [W:0] sb_q[$];
  logic [W:0] m_exp;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: WIDTH+1-bit two's-complement difference; top bit is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    sb_q.push_back(model(ia, ib, ibin));
    n_exp++;
  endtask

  // Called at the negedge of cycle 0; returns at the negedge of the done cycle.
  task automatic op_cycles(input bit poke, input bit hold_en, input logic [W-1:0] hold_v,
                           input bit b2b, input logic [W-1:0] na, input logic [W-1:0] nb,
                           input logic nbin);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
      end
      chk("busy_during_op", busy, 1);
      chk("done_during_op", done, 0);
      if (hold_en) chk("diff_hold", diff, hold_v);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    if (b2b) launch(na, nb, nbin);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        m_exp = sb_q.pop_front();
        chk("diff", diff, m_exp[W-1:0]);
        chk("bout", bout, m_exp[W]);
        n_done++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] va[6] = '{4'd9, 4'd3, 4'd0, 4'd7, 4'd15, 4'd0};
  logic [W-1:0] vb[6] = '{4'd3, 4'd9, 4'd0, 4'd7, 4'd0,  4'd15};
  logic         vc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1'b1};

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i], vc[i]);
      op_cycles(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("after_done", done, 0);
    end

    // Start pulse mid-operation must be ignored and not queued.
    launch(4'd9, 4'd3, 1'b0);
    op_cycles(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (W + 2) begin
      @(negedge clk);
      chk("no_second_done", done, 0);
      chk("no_second_busy", busy, 0);
    end

    // Back-to-back: second start issued in the done cycle.
    launch(4'd9, 4'd3, 1'b0);
    op_cycles(1'b0, 1'b0, '0, 1'b1, 4'd5, 4'd6, 1'b0);
    op_cycles(1'b0, 1'b1, 4'd6, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("b2b_after_done", done, 0);

    // Asynchronous reset mid-operation.
    launch(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_diff", diff, 0);
    chk("arst_bout", bout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    sb_q.delete();
    n_exp--;
    @(negedge clk);
    chk("arst_hold_done", done, 0);
    rst = 1'b0;
    repeat (W + 1) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    launch(4'd4, 4'd1, 1'b0);
    op_cycles(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);

    chk("done_count", n_done, n_exp);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
